uart16550_axil_rxfifo: RTL and testbench

Parametrised receive FIFO for the 16550 AXI-Lite UART, the successor to the fixed 16×8 FIFO. Each entry holds a data character plus its per-character error flags (parity, framing, break). The block also provides:
- 16550 trigger-level detection;
- an error-in-FIFO indication for LSR bit 7;
- the 4-character-time RX timeout;
- a 16450 single-register mode with overwrite-on-overrun.

It sits between the receiver shift logic and the register file.

---
 rtl/uart16550_axil_pkg.sv | 28 ++
 rtl/uart16550_axil_fifo_mem.sv | 31 +++
 rtl/uart16550_axil_rxfifo.sv | 131 +++++++++++++
 tb/tb_uart16550_axil_rxfifo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart16550_axil_pkg.sv
// Shared constants for the 16550 AXI-Lite UART receive path: trigger encodings,
// error-flag bit positions and the character-timeout length.
package uart16550_axil_pkg;

  localparam logic [1:0] TRIG_1  = 2'b00;
  localparam logic [1:0] TRIG_Q  = 2'b01;
  localparam logic [1:0] TRIG_H  = 2'b10;
  localparam logic [1:0] TRIG_HI = 2'b11;

  localparam int ERR_PE = 0;
  localparam int ERR_FE = 1;
  localparam int ERR_BI = 2;

  localparam int TOUT_CHARS = 4;

  // Occupancy threshold for a trig_sel code in a FIFO of the given depth.
  function automatic int trig_level(input logic [1:0] sel, input int depth);
    int lvl;
    case (sel)
      TRIG_1:  lvl = 1;
      TRIG_Q:  lvl = depth / 4;
      TRIG_H:  lvl = depth / 2;
      default: lvl = depth - 2;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart16550_axil_fifo_mem.sv
// Receive FIFO storage: one synchronous write port, one asynchronous read port,
// contents cleared only by reset.
module uart16550_axil_fifo_mem
  import uart16550_axil_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 11,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart16550_axil_rxfifo.sv
// 16550 receive FIFO with per-character error flags, trigger detection,
// error-in-FIFO indication, character timeout and 16450 single-register mode.
module uart16550_axil_rxfifo
  import uart16550_axil_pkg::*;
#(
  parameter  int DWIDTH = 8,
  parameter  int EWIDTH = 3,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              regmode,
  input  logic              flush,
  input  logic [1:0]        trig_sel,
  input  logic [DWIDTH-1:0] idata,
  input  logic [EWIDTH-1:0] ierr,
  input  logic              write,
  input  logic              read,
  output logic [DWIDTH-1:0] odata,
  output logic [EWIDTH-1:0] oerr,
  output logic [AW:0]       elems,
  output logic              empty,
  output logic              full,
  output logic              trig,
  output logic              fifoerr,
  output logic              oeflag,
  input  logic              clear_flag,
  input  logic              tout_tick,
  output logic              timeout
);

  localparam int W = DWIDTH + EWIDTH;

  logic [AW-1:0] rd_ptr, wr_ptr, mem_waddr;
  logic [AW:0]   elems_q, err_cnt, cap, level;
  logic [2:0]    tout_cnt;
  logic          regmode_q;
  logic [W-1:0]  head;
  logic          is_empty, is_full, do_flush;
  logic          wr_acc, rd_acc, overwrite, drop, mem_we;
  logic          err_inc, err_dec;

  assign cap   = regmode_q ? (AW+1)'(1) : (AW+1)'(DEPTH);
  assign level = regmode_q ? (AW+1)'(1) : (AW+1)'(trig_level(trig_sel, DEPTH));

  assign is_empty = (elems_q == '0);
  assign is_full  = (elems_q == cap);

  // A mode change empties the FIFO exactly like an FCR flush.
  assign do_flush = flush | (regmode != regmode_q);

  // Reading a full FIFO frees the slot the simultaneous write needs.
  assign rd_acc    = read & ~is_empty & ~do_flush;
  assign wr_acc    = write & (~is_full | read) & ~do_flush;
  assign overwrite = write & ~read & is_full &  regmode_q & ~do_flush;
  assign drop      = write & ~read & is_full & ~regmode_q & ~do_flush;

  assign mem_we    = wr_acc | overwrite;
  assign mem_waddr = overwrite ? rd_ptr : wr_ptr;

  assign err_inc = mem_we & (|ierr);
  assign err_dec = (rd_acc | overwrite) & (|head[W-1:DWIDTH]);

  uart16550_axil_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   ({ierr, idata}),
    .raddr   (rd_ptr),
    .rdata   (head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      elems_q   <= '0;
      err_cnt   <= '0;
      regmode_q <= 1'b0;
    end else begin
      regmode_q <= regmode;
      if (do_flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        elems_q <= '0;
        err_cnt <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        elems_q <= elems_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
        err_cnt <= err_cnt + {{AW{1'b0}}, err_inc} - {{AW{1'b0}}, err_dec};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oeflag <= 1'b0;
    end else if (overwrite | drop) begin
      oeflag <= 1'b1;
    end else if (clear_flag) begin
      oeflag <= 1'b0;
    end
  end

  // Counts idle character times while data waits in the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tout_cnt <= '0;
    end else if (do_flush | read | write | is_empty) begin
      tout_cnt <= '0;
    end else if (tout_tick && tout_cnt != 3'(TOUT_CHARS)) begin
      tout_cnt <= tout_cnt + 3'd1;
    end
  end

  assign odata   = head[DWIDTH-1:0];
  assign oerr    = head[W-1:DWIDTH];
  assign elems   = elems_q;
  assign empty   = is_empty;
  assign full    = is_full;
  assign trig    = (elems_q >= level);
  assign fifoerr = (err_cnt != '0);
  assign timeout = (tout_cnt == 3'(TOUT_CHARS));

endmodule

// File: tb/tb_uart16550_axil_rxfifo.sv
// Self-checking bench for uart16550_axil_rxfifo: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_uart16550_axil_rxfifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       regmode, flush, write, read, clear_flag, tout_tick;
  logic [1:0] trig_sel;
  logic [7:0] idata;
  logic [2:0] ierr;
  logic [7:0] odata;
  logic [2:0] oerr;
  logic [4:0] elems;
  logic       empty, full, trig, fifoerr, oeflag, timeout;

  int num_checks = 0;
  int num_errors = 0;

  logic [10:0] mq[$];
  bit          m_oe;
  int          m_tcnt;
  bit          m_rmq;

  always #5 clk = ~clk;

  uart16550_axil_rxfifo #(
    .DWIDTH (8),
    .EWIDTH (3),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .regmode    (regmode),
    .flush      (flush),
    .trig_sel   (trig_sel),
    .idata      (idata),
    .ierr       (ierr),
    .write      (write),
    .read       (read),
    .odata      (odata),
    .oerr       (oerr),
    .elems      (elems),
    .empty      (empty),
    .full       (full),
    .trig       (trig),
    .fifoerr    (fifoerr),
    .oeflag     (oeflag),
    .clear_flag (clear_flag),
    .tout_tick  (tout_tick),
    .timeout    (timeout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue of {err,data}; rules applied per edge.
  task automatic modelStep();
    int cap;
    bit was_empty, fl, ovf;
    cap       = m_rmq ? 1 : DEPTH;
    was_empty = (mq.size() == 0);
    fl        = flush || (regmode != m_rmq);
    ovf       = 1'b0;
    if (fl) begin
      mq.delete();
    end else if (write && !read && mq.size() == cap) begin
      ovf = 1'b1;
      if (m_rmq) mq[0] = {ierr, idata};
    end else begin
      if (read && !was_empty) mq.delete(0);
      if (write) mq.push_back({ierr, idata});
    end
    if (ovf) m_oe = 1'b1;
    else if (clear_flag) m_oe = 1'b0;
    if (fl || read || write || was_empty) m_tcnt = 0;
    else if (tout_tick && m_tcnt < 4) m_tcnt++;
    m_rmq = regmode;
  endtask

  task automatic compareAll();
    int lvl;
    bit anyerr;
    if (m_rmq) lvl = 1;
    else case (trig_sel)
      2'd0:    lvl = 1;
      2'd1:    lvl = DEPTH / 4;
      2'd2:    lvl = DEPTH / 2;
      default: lvl = DEPTH - 2;
    endcase
    anyerr = 1'b0;
    foreach (mq[i]) if (mq[i][10:8] != 3'd0) anyerr = 1'b1;
    checkOutput("elems",   32'(elems),   32'(mq.size()));
    checkOutput("empty",   32'(empty),   32'(mq.size() == 0));
    checkOutput("full",    32'(full),    32'(mq.size() == (m_rmq ? 1 : DEPTH)));
    checkOutput("trig",    32'(trig),    32'(mq.size() >= lvl));
    checkOutput("fifoerr", 32'(fifoerr), 32'(anyerr));
    checkOutput("oeflag",  32'(oeflag),  32'(m_oe));
    checkOutput("timeout", 32'(timeout), 32'(m_tcnt == 4));
    if (mq.size() > 0) begin
      checkOutput("odata", 32'(odata), 32'(mq[0][7:0]));
      checkOutput("oerr",  32'(oerr),  32'(mq[0][10:8]));
    end
  endtask

  task automatic applyStimulus(input bit w, input bit r, input logic [7:0] d,
                               input logic [2:0] e, input bit fl, input bit clr,
                               input bit tk);
    write = w; read = r; idata = d; ierr = e;
    flush = fl; clear_flag = clr; tout_tick = tk;
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  initial begin
    reset_n = 1'b0;
    regmode = 1'b0; flush = 1'b0; write = 1'b0; read = 1'b0;
    clear_flag = 1'b0; tout_tick = 1'b0; trig_sel = 2'b11;
    idata = '0; ierr = '0;
    m_oe = 1'b0; m_tcnt = 0; m_rmq = 1'b0;

    #22;
    compareAll();
    checkOutput("rst_odata", 32'(odata), 32'h0);
    checkOutput("rst_oerr",  32'(oerr),  32'h0);
    reset_n = 1'b1;

    $display("[TB] fill to full and overflow");
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 8'(i), 3'd0, 0, 0, 0);
    checkOutput("fill_elems", 32'(elems), 32'd16);
    checkOutput("fill_full",  32'(full),  32'd1);
    checkOutput("fill_trig",  32'(trig),  32'd1);
    applyStimulus(1, 0, 8'hFF, 3'd0, 0, 0, 0);
    checkOutput("ovf_oeflag", 32'(oeflag), 32'd1);
    checkOutput("ovf_odata",  32'(odata),  32'h00);
    applyStimulus(1, 0, 8'hEE, 3'd0, 0, 1, 0);
    checkOutput("ovf_setwins", 32'(oeflag), 32'd1);
    applyStimulus(0, 0, 8'h00, 3'd0, 0, 1, 0);

    $display("[TB] full streaming across wrap");
    for (int i = 0; i < 100; i++) applyStimulus(1, 1, 8'(8'h10 + i), 3'd0, 0, 0, 0);
    checkOutput("stream_elems",  32'(elems),  32'd16);
    checkOutput("stream_oeflag", 32'(oeflag), 32'd0);

    $display("[TB] error tracking");
    applyStimulus(0, 0, 8'h00, 3'd0, 1, 0, 0);
    applyStimulus(1, 0, 8'h41, 3'b010, 0, 0, 0);
    applyStimulus(1, 0, 8'h42, 3'b000, 0, 0, 0);
    checkOutput("err_fifoerr", 32'(fifoerr), 32'd1);
    checkOutput("err_oerr",    32'(oerr),    32'b010);
    applyStimulus(0, 1, 8'h00, 3'd0, 0, 0, 0);
    checkOutput("err_cleared", 32'(fifoerr), 32'd0);

    $display("[TB] 16450 register mode");
    regmode = 1'b1;
    applyStimulus(0, 0, 8'h00, 3'd0, 0, 0, 0);
    applyStimulus(1, 0, 8'h11, 3'd0, 0, 0, 0);
    applyStimulus(1, 0, 8'h22, 3'd0, 0, 0, 0);
    checkOutput("rm_elems",  32'(elems),  32'd1);
    checkOutput("rm_full",   32'(full),   32'd1);
    checkOutput("rm_odata",  32'(odata),  32'h22);
    checkOutput("rm_oeflag", 32'(oeflag), 32'd1);
    regmode = 1'b0;
    applyStimulus(0, 0, 8'h00, 3'd0, 0, 0, 0);
    checkOutput("rm_flush_elems",  32'(elems),  32'd0);
    checkOutput("rm_flush_oeflag", 32'(oeflag), 32'd1);
    applyStimulus(0, 0, 8'h00, 3'd0, 0, 1, 0);

    $display("[TB] character timeout");
    applyStimulus(1, 0, 8'h33, 3'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 3'd0, 0, 0, 1);
    checkOutput("tout_set", 32'(timeout), 32'd1);
    applyStimulus(0, 1, 8'h00, 3'd0, 0, 0, 0);
    checkOutput("tout_read", 32'(timeout), 32'd0);
    applyStimulus(1, 0, 8'h34, 3'd0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 3'd0, 0, 0, 1);
    applyStimulus(0, 0, 8'h00, 3'd0, 0, 0, 1);
    applyStimulus(1, 0, 8'h35, 3'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 3'd0, 0, 0, 1);
    checkOutput("tout_restart", 32'(timeout), 32'd0);
    applyStimulus(0, 0, 8'h00, 3'd0, 0, 0, 1);
    checkOutput("tout_after4", 32'(timeout), 32'd1);

    $display("[TB] flush versus write");
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 8'(8'hA0 + i), (i == 3) ? 3'b001 : 3'b000, 0, 0, 0);
    applyStimulus(1, 0, 8'h55, 3'b100, 1, 0, 0);
    checkOutput("flush_elems",   32'(elems),   32'd0);
    checkOutput("flush_empty",   32'(empty),   32'd1);
    checkOutput("flush_fifoerr", 32'(fifoerr), 32'd0);
    applyStimulus(1, 0, 8'h66, 3'd0, 0, 0, 0);
    checkOutput("flush_next", 32'(odata), 32'h66);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      bit w, r, fl, clr, tk;
      logic [2:0] e;
      if ($urandom_range(0, 199) == 0) regmode = ~regmode;
      if ($urandom_range(0, 49) == 0) trig_sel = 2'($urandom_range(0, 3));
      if ((i / 250) % 2 == 0) begin
        w = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 4);
      end else begin
        w = ($urandom_range(0, 9) < 4);
        r = ($urandom_range(0, 9) < 7);
      end
      if ($urandom_range(0, 9) < 3) begin
        w = 1'b0;
        r = 1'b0;
      end
      fl  = ($urandom_range(0, 79) == 0);
      clr = ($urandom_range(0, 9) == 0);
      tk  = ($urandom_range(0, 2) == 0);
      e   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      applyStimulus(w, r, 8'($urandom), e, fl, clr, tk);
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
